page_selector: RTL and testbench
================================

Name: page_selector

Overview:
- Input side of the page display: turns raw front-panel buttons into the 10-bit page number that the 7-segment page recorder shows.
- Synchronises and debounces next/prev/home buttons, steps the page on each press with auto-repeat while held, and wraps within 1..total pages.
- Drives page[9:0] and a one-cycle page_changed strobe that the comic-page fetch logic uses to start loading a new image.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, cycles a button level must be stable before acceptance (10 ms at 100 MHz).
- REPEAT_DELAY, 50_000_000, hold time after the first step before auto-repeat starts (500 ms).
- REPEAT_PERIOD, 10_000_000, interval between auto-repeat steps (100 ms).
- PAGE_MAX, 999, upper page bound used when total_pages is 0 or greater than PAGE_MAX; must be ≤ 1023.

Ports:
- clk100mhz, input, 1, system clock, 100 MHz.
- rst, input, 1, synchronous active-high reset.
- btn_next, input, 1, raw asynchronous button; 1 = pressed.
- btn_prev, input, 1, raw asynchronous button; 1 = pressed.
- btn_home, input, 1, raw asynchronous button; 1 = pressed; returns to page 1.
- total_pages, input, 10, page count of the loaded book; 0 means use PAGE_MAX.
- page, output, 10, current page, always in 1..limit.
- page_changed, output, 1, one-cycle strobe in the cycle after page takes a new value.

Behaviour:
- One clock: clk100mhz. Reset is synchronous and active-high (rst).
- Reset values:
  - page = 1, page_changed = 0.
  - Debouncers clear to "released" with counters at 0.
  - FSM goes to IDLE and repeat counter to 0.
- limit = PAGE_MAX if total_pages == 0 or total_pages > PAGE_MAX; otherwise total_pages.
- Input conditioning:
  - Each button passes through a 2-flop synchroniser, then a debouncer.
  - The debouncer's clean level changes only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts the count.
- Command decode, from clean levels:
  - home has priority.
  - next and prev both high is treated as no command.
- FSM states: IDLE, STEP, HOLD, REPEAT.
- IDLE:
  - On a clean rising edge of a valid command, latch the direction and go to STEP.
  - Pressing home sets page = 1 and returns to IDLE; home never auto-repeats.
- STEP, one cycle:
  - Apply one step.
  - Next at limit wraps to 1.
  - Prev at 1 wraps to limit.
  - Otherwise page ±1.
  - Load the repeat counter, then go to HOLD.
- HOLD:
  - Count REPEAT_DELAY cycles, then go to REPEAT.
  - If the latched button releases, or the command becomes invalid (other direction pressed, or home pressed), go to IDLE with no step.
- REPEAT:
  - Apply one step every REPEAT_PERIOD cycles.
  - Same exit conditions as HOLD.
- page_changed:
  - Asserted exactly one cycle after any cycle that changes page.
  - Not asserted when the new value equals the old one (home at page 1; step with limit == 1).
- Clamp:
  - If limit drops below page at any time, page becomes limit on the next cycle and page_changed pulses.
  - Clamp takes priority over a step in the same cycle.
- rst mid-hold: immediate return to reset values. Buttons still held after reset release must first be seen released, then pressed again, before they act.
- Latency: raw press → page update = 2 sync + DEBOUNCE_CYCLES + 2 cycles, deterministic to ±1 cycle.
- Counters are sized with $clog2 of their parameter.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package (page_pkg):
  - PAGE_W = 10.
  - Command enum {CMD_NONE, CMD_NEXT, CMD_PREV, CMD_HOME}.
  - Default PAGE_MAX.
  - The page_recorder width constant also reuses PAGE_W.
- Sub-module btn_debounce (param CYCLES):
  - Contains synchroniser plus debounce counter.
  - Outputs the clean level and a rise pulse.
  - Instantiated three times.

Test Plan (sim with DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 20, REPEAT_PERIOD = 5, total_pages = 12):
- Reset, no buttons → page = 1, page_changed = 0 for 100 cycles.
- Single next pulse held 10 cycles, with 3-cycle bounce before it → exactly one step: page = 2, one page_changed pulse; the bounce alone produces no step.
- Prev held from page 1 → page = 12 immediately, then 11, 10, … one step every 5 cycles starting 20 cycles after the first step; release stops stepping within 1 cycle of the clean release.
- At page 12, next → page = 1. Next and prev pressed together → no change and no strobe.
- Page 9 while next is held, total_pages switched to 5 → page = 5 next cycle with one strobe. Then home → page = 1.
- rst asserted during REPEAT with next still held → page = 1, and no step occurs until next is released and pressed again.

Source files
------------

// File: rtl/page_pkg.sv
// Shared page-display types and constants.
// Used by the page selector and the page recorder.
package page_pkg;

  localparam int PAGE_W = 10;
  localparam int REC_W  = PAGE_W;
  localparam logic [PAGE_W-1:0] PAGE_MAX_DEF = 10'd999;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_NEXT,
    CMD_PREV,
    CMD_HOME
  } cmd_e;

  // One step in the latched direction, wrapping within 1..limit.
  function automatic logic [PAGE_W-1:0] page_step(
    input logic [PAGE_W-1:0] pg,
    input cmd_e              dir,
    input logic [PAGE_W-1:0] lim
  );
    logic [PAGE_W-1:0] r;
    r = pg;
    if (dir == CMD_NEXT)
      r = (pg >= lim) ? PAGE_W'(1) : pg + 1'b1;
    else if (dir == CMD_PREV)
      r = (pg <= PAGE_W'(1)) ? lim : pg - 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser and debouncer.
// Rise pulses only after a clean release has been seen since reset.
module btn_debounce #(
  parameter int CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 2;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_s3;
  logic          r_level;
  logic          r_rise;
  logic          r_arm;
  logic [CW-1:0] r_cnt;
  logic          w_chg;
  logic          w_stable;

  // r_cnt = cycles the synced level has held its current value
  assign w_chg    = r_s2 != r_s3;
  assign w_stable = !w_chg && (r_cnt == LAST);

  // Sync, count stable cycles, accept level; arm after a clean low
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_arm   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1   <= i_btn;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_rise <= 1'b0;
      if (w_chg)
        r_cnt <= CW'(1);
      else if (r_cnt != LAST)
        r_cnt <= r_cnt + 1'b1;
      if (w_stable && (r_s2 != r_level)) begin
        r_level <= r_s2;
        r_rise  <= r_s2 & r_arm;
      end
      if (w_stable && !r_s2)
        r_arm <= 1'b1;
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/page_selector.sv
// Front-panel buttons to page number with auto-repeat.
// Page and strobe are registered; no input-to-output comb path.
module page_selector
  import page_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000,
  parameter logic [PAGE_W-1:0] PAGE_MAX = PAGE_MAX_DEF
) (
  input  logic              clk100mhz,
  input  logic              rst,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic              btn_home,
  input  logic [PAGE_W-1:0] total_pages,
  output logic [PAGE_W-1:0] page,
  output logic              page_changed
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 2) ? $clog2(RMAX) : 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_HOLD,
    S_REPEAT
  } state_e;

  state_e            r_state;
  cmd_e              r_dir;
  logic [RW-1:0]     r_rcnt;
  logic [PAGE_W-1:0] r_page;
  logic              r_changed;

  logic              w_lvl_next;
  logic              w_lvl_prev;
  logic              w_lvl_home;
  logic              w_rise_next;
  logic              w_rise_prev;
  logic              w_rise_home;
  logic [PAGE_W-1:0] w_limit;
  cmd_e              w_cmd;
  logic              w_start;
  logic              w_keep;
  logic              w_do_step;
  logic              w_clamp;
  logic [PAGE_W-1:0] w_page_nxt;

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .i_clk   (clk100mhz),
    .i_rst   (rst),
    .i_btn   (btn_next),
    .o_level (w_lvl_next),
    .o_rise  (w_rise_next)
  );

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
    .i_clk   (clk100mhz),
    .i_rst   (rst),
    .i_btn   (btn_prev),
    .o_level (w_lvl_prev),
    .o_rise  (w_rise_prev)
  );

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_home (
    .i_clk   (clk100mhz),
    .i_rst   (rst),
    .i_btn   (btn_home),
    .o_level (w_lvl_home),
    .o_rise  (w_rise_home)
  );

  assign w_limit = ((total_pages == '0) || (total_pages > PAGE_MAX)) ?
                   PAGE_MAX : total_pages;

  // Home wins; next and prev together cancel out
  always_comb begin
    w_cmd = CMD_NONE;
    if (w_lvl_home)
      w_cmd = CMD_HOME;
    else if (w_lvl_next && !w_lvl_prev)
      w_cmd = CMD_NEXT;
    else if (w_lvl_prev && !w_lvl_next)
      w_cmd = CMD_PREV;
  end

  assign w_start = (w_rise_next && (w_cmd == CMD_NEXT)) ||
                   (w_rise_prev && (w_cmd == CMD_PREV));
  assign w_keep  = (w_cmd == r_dir);
  assign w_clamp = (r_page > w_limit);

  assign w_do_step = (r_state == S_STEP) ||
                     (((r_state == S_HOLD) || (r_state == S_REPEAT)) &&
                      w_keep && (r_rcnt == '0));

  // Next page: clamp, then home, then step
  always_comb begin
    w_page_nxt = r_page;
    if (w_clamp)
      w_page_nxt = w_limit;
    else if (w_rise_home)
      w_page_nxt = PAGE_W'(1);
    else if (w_do_step)
      w_page_nxt = page_step(r_page, r_dir, w_limit);
  end

  // Page register; strobe only when the value actually moves
  always_ff @(posedge clk100mhz) begin
    if (rst) begin
      r_page    <= PAGE_W'(1);
      r_changed <= 1'b0;
    end else begin
      r_page    <= w_page_nxt;
      r_changed <= (w_page_nxt != r_page);
    end
  end

  // Press / hold / auto-repeat sequencing
  always_ff @(posedge clk100mhz) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_dir   <= CMD_NONE;
      r_rcnt  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_dir   <= w_cmd;
            r_state <= S_STEP;
          end
        end
        S_STEP: begin
          r_rcnt  <= RW'(REPEAT_DELAY - 1);
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (!w_keep) begin
            r_state <= S_IDLE;
          end else if (r_rcnt == '0) begin
            r_rcnt  <= RW'(REPEAT_PERIOD - 1);
            r_state <= S_REPEAT;
          end else begin
            r_rcnt <= r_rcnt - 1'b1;
          end
        end
        S_REPEAT: begin
          if (!w_keep)
            r_state <= S_IDLE;
          else if (r_rcnt == '0)
            r_rcnt <= RW'(REPEAT_PERIOD - 1);
          else
            r_rcnt <= r_rcnt - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign page         = r_page;
  assign page_changed = r_changed;

endmodule

// File: tb/tb_page_selector.sv
// Directed bench for page_selector with short timing parameters.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_page_selector;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_next;
  logic       btn_prev;
  logic       btn_home;
  logic [9:0] total_pages;
  logic [9:0] page;
  logic       page_changed;

  int checks   = 0;
  int errors   = 0;
  int n_strobe = 0;

  page_selector #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (5),
    .PAGE_MAX        (10'd999)
  ) dut (
    .clk100mhz    (clk),
    .rst          (rst),
    .btn_next     (btn_next),
    .btn_prev     (btn_prev),
    .btn_home     (btn_home),
    .total_pages  (total_pages),
    .page         (page),
    .page_changed (page_changed)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (page_changed === 1'b1)
      n_strobe++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++)
      tick();
  endtask

  // sel: 0 next, 1 prev, 2 home, 3 next+prev
  task automatic press(input int sel, input int hold, input int gap);
    btn_next = (sel == 0) || (sel == 3);
    btn_prev = (sel == 1) || (sel == 3);
    btn_home = (sel == 2);
    ticks(hold);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    btn_home = 1'b0;
    ticks(gap);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_next = 1'b0;
    btn_prev = 1'b0;
    btn_home = 1'b0;
    total_pages = 10'd12;
    ticks(3);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if ({page, page_changed} !== {10'd1, 1'b0}) begin
        errors++;
        $display("FAIL reset_idle t=%0d page=%0d chg=%b want 1/0",
                 i, page, page_changed);
      end
    end
  endtask

  task automatic test_next_bounce();
    int lat;
    n_strobe = 0;
    btn_next = 1'b1; tick();
    btn_next = 1'b0; tick();
    btn_next = 1'b1; tick();
    btn_next = 1'b0; ticks(8);
    checks++;
    if (page !== 10'd1 || n_strobe !== 0) begin
      errors++;
      $display("FAIL bounce page=%0d strobes=%0d want 1/0", page, n_strobe);
    end
    lat = 0;
    btn_next = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (lat == 0 && page !== 10'd1)
        lat = i;
    end
    btn_next = 1'b0;
    ticks(25);
    checks++;
    if (page !== 10'd2) begin
      errors++;
      $display("FAIL next_step page=%0d want 2", page);
    end
    checks++;
    if (n_strobe !== 1) begin
      errors++;
      $display("FAIL next_strobe count=%0d want 1", n_strobe);
    end
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL next_latency got=%0d want 8", lat);
    end
  endtask

  task automatic test_prev_repeat();
    int n;
    int exp;
    press(2, 10, 12);
    checks++;
    if (page !== 10'd1) begin
      errors++;
      $display("FAIL home page=%0d want 1", page);
    end
    n_strobe = 0;
    btn_prev = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      tick();
      n = (i >= 28) ? 1 + (i - 28) / 5 : 0;
      if (n > 5) n = 5;
      exp = (i < 8) ? 1 : 12 - n;
      checks++;
      if (page !== 10'(exp)) begin
        errors++;
        $display("FAIL prev_repeat t=%0d page=%0d want %0d", i, page, exp);
      end
      if (i == 45)
        btn_prev = 1'b0;
    end
    checks++;
    if (n_strobe !== 6) begin
      errors++;
      $display("FAIL prev_strobes count=%0d want 6", n_strobe);
    end
  endtask

  task automatic test_wrap_conflict();
    press(2, 10, 12);
    press(1, 10, 20);
    checks++;
    if (page !== 10'd12) begin
      errors++;
      $display("FAIL prev_wrap page=%0d want 12", page);
    end
    n_strobe = 0;
    press(0, 10, 20);
    checks++;
    if (page !== 10'd1 || n_strobe !== 1) begin
      errors++;
      $display("FAIL next_wrap page=%0d strobes=%0d want 1/1",
               page, n_strobe);
    end
    n_strobe = 0;
    press(3, 15, 15);
    checks++;
    if (page !== 10'd1 || n_strobe !== 0) begin
      errors++;
      $display("FAIL both page=%0d strobes=%0d want 1/0", page, n_strobe);
    end
  endtask

  task automatic test_clamp_home();
    for (int k = 0; k < 5; k++)
      press(1, 10, 20);
    checks++;
    if (page !== 10'd8) begin
      errors++;
      $display("FAIL to_eight page=%0d want 8", page);
    end
    btn_next = 1'b1;
    ticks(12);
    checks++;
    if (page !== 10'd9) begin
      errors++;
      $display("FAIL held_nine page=%0d want 9", page);
    end
    total_pages = 10'd5;
    n_strobe = 0;
    tick();
    checks++;
    if (page !== 10'd5 || page_changed !== 1'b1) begin
      errors++;
      $display("FAIL clamp page=%0d chg=%b want 5/1", page, page_changed);
    end
    btn_next = 1'b0;
    ticks(25);
    checks++;
    if (page !== 10'd5 || n_strobe !== 1) begin
      errors++;
      $display("FAIL clamp_hold page=%0d strobes=%0d want 5/1",
               page, n_strobe);
    end
    press(2, 10, 12);
    checks++;
    if (page !== 10'd1) begin
      errors++;
      $display("FAIL home_after page=%0d want 1", page);
    end
    n_strobe = 0;
    press(2, 10, 12);
    checks++;
    if (page !== 10'd1 || n_strobe !== 0) begin
      errors++;
      $display("FAIL home_at_one page=%0d strobes=%0d want 1/0",
               page, n_strobe);
    end
    total_pages = 10'd1;
    n_strobe = 0;
    press(0, 10, 20);
    checks++;
    if (page !== 10'd1 || n_strobe !== 0) begin
      errors++;
      $display("FAIL limit_one page=%0d strobes=%0d want 1/0",
               page, n_strobe);
    end
    total_pages = 10'd0;
    press(1, 10, 20);
    checks++;
    if (page !== 10'd999) begin
      errors++;
      $display("FAIL zero_total page=%0d want 999", page);
    end
    total_pages = 10'd12;
    tick();
    checks++;
    if (page !== 10'd12) begin
      errors++;
      $display("FAIL clamp_12 page=%0d want 12", page);
    end
    press(2, 10, 12);
  endtask

  task automatic test_reset_mid_repeat();
    btn_next = 1'b1;
    ticks(35);
    checks++;
    if (page !== 10'd4) begin
      errors++;
      $display("FAIL repeat_pre page=%0d want 4", page);
    end
    rst = 1'b1;
    ticks(2);
    checks++;
    if (page !== 10'd1 || page_changed !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset page=%0d chg=%b want 1/0",
               page, page_changed);
    end
    rst = 1'b0;
    n_strobe = 0;
    ticks(40);
    checks++;
    if (page !== 10'd1 || n_strobe !== 0) begin
      errors++;
      $display("FAIL held_after_rst page=%0d strobes=%0d want 1/0",
               page, n_strobe);
    end
    btn_next = 1'b0;
    ticks(15);
    checks++;
    if (page !== 10'd1) begin
      errors++;
      $display("FAIL release_rst page=%0d want 1", page);
    end
    press(0, 10, 20);
    checks++;
    if (page !== 10'd2) begin
      errors++;
      $display("FAIL repress page=%0d want 2", page);
    end
  endtask

  initial begin
    test_reset();
    test_next_bounce();
    test_prev_repeat();
    test_wrap_conflict();
    test_clamp_home();
    test_reset_mid_repeat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
